booth_r4_mul: RTL and testbench

//  Parametrised sequential radix-4 Booth multiplier, next generation of the 8-bit ALU multiplier.

---
 rtl/booth_pkg.sv | 36 +++
 rtl/booth_r4_recoder.sv | 42 ++++
 rtl/booth_r4_mul.sv | 126 ++++++++++++
 tb/tb_booth_r4_mul.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    ZERO = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    DIG_NOP  = 3'd0,
    DIG_ADD1 = 3'd1,
    DIG_ADD2 = 3'd2,
    DIG_SUB1 = 3'd3,
    DIG_SUB2 = 3'd4
  } digit_e;

  // Number of Booth digits retired for a given operand width.
  function automatic int unsigned ndig(input int unsigned width);
    return width / 2 + 1;
  endfunction

  // Standard radix-4 recoding of a {Q[i+1], Q[i], Q[i-1]} triplet.
  function automatic digit_e booth_digit(input logic [2:0] trip);
    digit_e dig;
    case (trip)
      3'b001, 3'b010: dig = DIG_ADD1;
      3'b011:         dig = DIG_ADD2;
      3'b100:         dig = DIG_SUB2;
      3'b101, 3'b110: dig = DIG_SUB1;
      default:        dig = DIG_NOP;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Turns one Booth triplet and the extended multiplicand into an adder operand
// plus carry-in; subtraction is expressed as ~Y with carry-in 1.
module booth_r4_recoder
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       trip_i,
  input  logic [WIDTH:0]   m_ext_i,
  output logic [WIDTH+2:0] addend_o,
  output logic             cin_o
);

  localparam int unsigned AW = WIDTH + 3;

  digit_e          dig;
  logic [AW-1:0]   m1;
  logic [AW-1:0]   m2;

  assign dig = booth_digit(trip_i);
  assign m1  = {{2{m_ext_i[WIDTH]}}, m_ext_i};
  assign m2  = {m_ext_i[WIDTH], m_ext_i, 1'b0};

  always_comb begin
    addend_o = '0;
    cin_o    = 1'b0;
    case (dig)
      DIG_ADD1: addend_o = m1;
      DIG_ADD2: addend_o = m2;
      DIG_SUB1: begin
        addend_o = ~m1;
        cin_o    = 1'b1;
      end
      DIG_SUB2: begin
        addend_o = ~m2;
        cin_o    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/booth_r4_mul.sv
// Sequential radix-4 Booth multiplier: one digit per clock, signed or unsigned
// operands, start/busy/done handshake with a held product register.
module booth_r4_mul
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned N_DIG = ndig(WIDTH);
  localparam int unsigned CNT_W = $clog2(N_DIG);
  localparam int unsigned AW    = WIDTH + 3;
  localparam int unsigned QW    = WIDTH + 3;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_DIG - 1);

  state_e             state_q, state_d;
  logic [AW-1:0]      a_q, a_d;
  logic [QW-1:0]      q_q, q_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [PW-1:0]      prod_q, prod_d;

  logic [AW-1:0]      addend;
  logic               cin;
  logic [AW-1:0]      sum;
  logic [AW+QW-1:0]   shifted;
  logic               sx_m;
  logic               sx_q;

  booth_r4_recoder #(.WIDTH(WIDTH)) u_recoder (
    .trip_i   (q_q[2:0]),
    .m_ext_i  (m_q),
    .addend_o (addend),
    .cin_o    (cin)
  );

  // Q register carries Q[-1] in bit 0, so the low triplet is always the next digit.
  assign sum     = a_q + addend + AW'(cin);
  assign shifted = {{2{sum[AW-1]}}, sum, q_q[QW-1:2]};
  assign sx_m    = is_signed & multiplicand[WIDTH-1];
  assign sx_q    = is_signed & multiplier[WIDTH-1];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d    = {sx_m, multiplicand};
          q_d    = {{2{sx_q}}, multiplier, 1'b0};
          a_d    = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
          if (multiplicand == '0 || multiplier == '0) begin
            state_d = ZERO;
          end else begin
            state_d = ITER;
          end
        end
      end
      ITER: begin
        a_d   = shifted[AW+QW-1:QW];
        q_d   = shifted[QW-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          prod_d  = shifted[PW:1];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      ZERO: begin
        prod_d  = '0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_booth_r4_mul.sv
// Self-checking bench for booth_r4_mul at WIDTH=8 and WIDTH=16.
module tb_booth_r4_mul;

  logic        clk;
  logic        rst8_n, rst16_n;
  logic        st8, s8, st16, s16;
  logic [7:0]  m8, q8;
  logic [15:0] m16, q16;
  logic        busy8, done8, busy16, done16;
  logic [15:0] p8;
  logic [31:0] p16;

  int n_cmp;
  int n_bad;

  booth_r4_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst8_n), .start(st8), .is_signed(s8),
    .multiplicand(m8), .multiplier(q8),
    .busy(busy8), .done(done8), .product(p8)
  );

  booth_r4_mul #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst16_n), .start(st16), .is_signed(s16),
    .multiplicand(m16), .multiplier(q16),
    .busy(busy16), .done(done16), .product(p16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sgn;
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference product computed from plain integer arithmetic.
  function automatic logic [31:0] ref_mul(input int w, input bit sgn,
                                          input logic [15:0] a, input logic [15:0] b);
    longint x, y, p;
    x = longint'(a);
    y = longint'(b);
    if (sgn && a[w-1]) x -= (longint'(1) << w);
    if (sgn && b[w-1]) y -= (longint'(1) << w);
    p = x * y;
    if (w == 8) return {16'h0, p[15:0]};
    return p[31:0];
  endfunction

  // Issue one operation and wait (bounded) for done; lat counts edges after accept.
  task automatic run_op(input int w, input bit sgn, input logic [15:0] a,
                        input logic [15:0] b, output logic [31:0] prod, output int lat);
    @(negedge clk);
    if (w == 8) begin
      s8 = sgn; m8 = a[7:0]; q8 = b[7:0]; st8 = 1'b1;
    end else begin
      s16 = sgn; m16 = a; q16 = b; st16 = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    st8 = 1'b0;
    st16 = 1'b0;
    check("busy_after_accept", 32'(w == 8 ? busy8 : busy16), 32'd1);
    lat = 0;
    while (!(w == 8 ? done8 : done16) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    prod = (w == 8) ? {16'h0, p8} : p16;
  endtask

  vec_t        vecs[$];
  logic [31:0] prod;
  int          lat;
  bit          seen;

  initial begin
    n_cmp = 0; n_bad = 0;
    st8 = 0; s8 = 0; m8 = '0; q8 = '0;
    st16 = 0; s16 = 0; m16 = '0; q16 = '0;
    rst8_n = 0; rst16_n = 0;
    #1;
    check("reset_busy", 32'(busy8), 32'd0);
    check("reset_done", 32'(done8), 32'd0);
    check("reset_product", 32'(p8), 32'd0);
    repeat (2) @(negedge clk);
    rst8_n = 1; rst16_n = 1;

    vecs.push_back('{1'b1, 8'd13,  8'd28,  16'd364,  5});
    vecs.push_back('{1'b1, 8'hF9,  8'h05,  16'hFFDD, 5});
    vecs.push_back('{1'b1, 8'h80,  8'h80,  16'h4000, 5});
    vecs.push_back('{1'b0, 8'hFF,  8'hFF,  16'hFE01, 5});
    vecs.push_back('{1'b1, 8'hFF,  8'hFF,  16'h0001, 5});
    vecs.push_back('{1'b1, 8'h7F,  8'h80,  16'hC080, 5});
    vecs.push_back('{1'b0, 8'h80,  8'h80,  16'h4000, 5});
    vecs.push_back('{1'b0, 8'h00,  8'h5A,  16'h0000, 1});
    vecs.push_back('{1'b1, 8'hA5,  8'h00,  16'h0000, 1});

    foreach (vecs[i]) begin
      run_op(8, vecs[i].sgn, {8'h0, vecs[i].m}, {8'h0, vecs[i].q}, prod, lat);
      check($sformatf("vec%0d_product", i), prod, {16'h0, vecs[i].exp});
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_busy_at_done", i), 32'(busy8), 32'd0);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 32'(done8), 32'd0);
    end

    // start re-pulsed mid-operation with new operands is ignored
    @(negedge clk);
    s8 = 1; m8 = 8'd13; q8 = 8'd28; st8 = 1;
    @(posedge clk);
    @(negedge clk);
    s8 = 0; m8 = 8'd3; q8 = 8'd3;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 2) st8 = 0;
    end
    st8 = 0;
    check("repulse_product", 32'(p8), 32'd364);
    check("repulse_latency", 32'(lat), 32'd5);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done8 || busy8) seen = 1;
    end
    check("repulse_no_second_op", 32'(seen), 32'd0);

    // start held high through done: back-to-back acceptance
    s8 = 1; m8 = 8'd13; q8 = 8'd28; st8 = 1;
    @(posedge clk);
    @(negedge clk);
    s8 = 0; m8 = 8'd7; q8 = 8'd9;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_product", 32'(p8), 32'd364);
    check("b2b_first_latency", 32'(lat), 32'd5);
    @(posedge clk);
    @(negedge clk);
    st8 = 0;
    check("b2b_second_busy", 32'(busy8), 32'd1);
    lat = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_second_product", 32'(p8), 32'd63);
    check("b2b_second_latency", 32'(lat), 32'd5);

    // asynchronous reset in the middle of ITER (cnt == 2)
    @(negedge clk);
    s8 = 1; m8 = 8'h35; q8 = 8'h47; st8 = 1;
    @(posedge clk);
    @(negedge clk);
    st8 = 0;
    repeat (2) @(negedge clk);
    rst8_n = 0;
    #1;
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    check("midrst_product", 32'(p8), 32'd0);
    @(negedge clk);
    rst8_n = 1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done8 || busy8) seen = 1;
    end
    check("midrst_no_done", 32'(seen), 32'd0);

    // random sweep at both widths against the integer reference
    for (int w = 8; w <= 16; w += 8) begin
      for (int k = 0; k < 40; k++) begin
        logic [15:0] a, b;
        bit          sg;
        a  = 16'($urandom);
        b  = 16'($urandom);
        sg = 1'($urandom);
        if (w == 8) begin
          a[15:8] = '0;
          b[15:8] = '0;
        end
        if ($urandom_range(0, 9) == 0) a = '0;
        if ($urandom_range(0, 9) == 0) b = (w == 8) ? 16'h0080 : 16'h8000;
        run_op(w, sg, a, b, prod, lat);
        check($sformatf("rand_w%0d_%0d_s%0d_%h_%h", w, k, sg, a, b), prod, ref_mul(w, sg, a, b));
        check($sformatf("rand_w%0d_%0d_latency", w, k), 32'(lat),
              (a == '0 || b == '0) ? 32'd1 : 32'(w / 2 + 1));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
